// File: rtl/lcd_sequencer.sv
// HD44780 character-LCD bus sequencer: one-time power-up init, then four hex digits as ASCII at line 1, col 0.
// E is only ever high in STROBE; data/RS are registered and loaded on entry to SETUP.
module lcd_sequencer #(
  parameter int unsigned POWERUP_CYC    = 2000000,
  parameter int unsigned E_HIGH_CYC     = 50,
  parameter int unsigned CMD_WAIT_CYC   = 5000,
  parameter int unsigned CLEAR_WAIT_CYC = 200000
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] bit_A,
  input  logic [3:0] bit_B,
  input  logic [3:0] bit_C,
  input  logic [3:0] bit_D,
  output logic       busy,
  output logic       done,
  output logic [7:0] data,
  output logic       RS,
  output logic       RW,
  output logic       E
);

  localparam int unsigned MAX_A   = (POWERUP_CYC > E_HIGH_CYC) ? POWERUP_CYC : E_HIGH_CYC;
  localparam int unsigned MAX_B   = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC : CLEAR_WAIT_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int          CW      = $clog2(MAX_CYC + 1);

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t PWR_LAST = cnt_t'(POWERUP_CYC - 1);
  localparam cnt_t EH_LAST  = cnt_t'(E_HIGH_CYC - 1);
  localparam cnt_t CMD_LAST = cnt_t'(CMD_WAIT_CYC - 1);
  localparam cnt_t CLR_LAST = cnt_t'(CLEAR_WAIT_CYC - 1);

  // The NEXT decision has no cycle of its own; it is folded into the WAIT exit.
  typedef enum logic [2:0] {IDLE, POWERUP, SETUP, STROBE, WAIT} state_t;

  state_t      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] dig_q, dig_d;
  logic [7:0]  data_q, data_d;
  logic        rs_q, rs_d, init_q, init_d, done_q, done_d;
  logic        load, seq_end;
  cnt_t        wait_last;

  function automatic logic [7:0] to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [7:0] xfer_byte(input logic [3:0] idx, input logic [15:0] dig);
    case (idx)
      4'd0:    return 8'h38;
      4'd1:    return 8'h0C;
      4'd2:    return 8'h01;
      4'd3:    return 8'h06;
      4'd4:    return 8'h80;
      4'd5:    return to_ascii(dig[15:12]);
      4'd6:    return to_ascii(dig[11:8]);
      4'd7:    return to_ascii(dig[7:4]);
      default: return to_ascii(dig[3:0]);
    endcase
  endfunction

  assign wait_last = (!rs_q && data_q == 8'h01) ? CLR_LAST : CMD_LAST;

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    seq_end = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = init_q ? SETUP : POWERUP;
        load    = init_q;
      end
      POWERUP: if (cnt_q == PWR_LAST) begin
        state_d = SETUP;
        load    = 1'b1;
      end
      SETUP:  state_d = STROBE;
      STROBE: if (cnt_q == EH_LAST) state_d = WAIT;
      WAIT: if (cnt_q == wait_last) begin
        if (idx_q == 4'd8) begin
          state_d = IDLE;
          seq_end = 1'b1;
        end else begin
          state_d = SETUP;
          load    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    E    = (state_q == STROBE);
    RW   = 1'b0;
    done = done_q;
    data = data_q;
    RS   = rs_q;
  end

  // Counter restarts on every state change; byte for the next transfer is chosen from idx_d.
  always_comb begin
    cnt_d  = (state_d == state_q && state_q != IDLE) ? cnt_q + cnt_t'(1) : '0;
    dig_d  = dig_q;
    idx_d  = idx_q;
    if (state_q == IDLE && start) begin
      dig_d = {bit_A, bit_B, bit_C, bit_D};
      idx_d = init_q ? 4'd4 : 4'd0;
    end else if (load && state_q == WAIT) begin
      idx_d = idx_q + 4'd1;
    end
    data_d = data_q;
    rs_d   = rs_q;
    if (load) begin
      data_d = xfer_byte(idx_d, dig_d);
      rs_d   = (idx_d >= 4'd5);
    end
    init_d = init_q | seq_end;
    done_d = seq_end;
  end

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      dig_q  <= '0;
      data_q <= '0;
      rs_q   <= 1'b0;
      init_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      dig_q  <= dig_d;
      data_q <= data_d;
      rs_q   <= rs_d;
      init_q <= init_d;
      done_q <= done_d;
    end
  end

endmodule
